alu_shift_rotate_pipe: RTL and testbench



---
 rtl/alu_shift_pkg.sv | 35 +++
 rtl/alu_shift_stage.sv | 58 +++++
 rtl/alu_shift_rotate_pipe.sv | 88 ++++++++
 tb/tb_alu_shift_rotate_pipe.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_shift_pkg.sv
// Shared types and helpers for the pipelined shift/rotate unit.
// Stage records carry control state alongside the data and the remaining amount.
package alu_shift_pkg;

    localparam int MAX_N = 64;

    typedef enum logic [2:0] {
        OP_ROR = 3'd0,
        OP_ROL = 3'd1,
        OP_SRL = 3'd2,
        OP_SLL = 3'd3,
        OP_SRA = 3'd4
    } shift_op_e;

    // Width-independent part of a stage record; data and amount travel beside it.
    typedef struct packed {
        logic      valid;
        shift_op_e op;
        logic      fill;
        logic      carry;
        logic      err;
        logic      rev;
    } stage_ctl_t;

    // Reverses the low n bits of x; bits at and above n come back as zero.
    function automatic logic [MAX_N-1:0] bit_reverse(input logic [MAX_N-1:0] x, input int unsigned n);
        logic [MAX_N-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MAX_N; i++) begin
            if (i < n) r[i] = x[n-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_shift_stage.sv
// One pipeline stage: conditionally rotates or shifts right by SHIFT when the
// low bit of the remaining amount is set, then hands the amount on shifted down.
module alu_shift_stage
    import alu_shift_pkg::*;
#(
    parameter int N     = 8,
    parameter int SHIFT = 1,
    localparam int S    = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         adv,
    input  logic [N-1:0] data_in,
    input  logic [S-1:0] amt_in,
    input  stage_ctl_t   ctl_in,
    output logic [N-1:0] data_out,
    output logic [S-1:0] amt_out,
    output stage_ctl_t   ctl_out,
    output logic         zero_out
);

    logic         rotate;
    logic [N-1:0] data_next;
    logic [N-1:0] data_reg;
    logic [S-1:0] amt_reg;
    stage_ctl_t   ctl_reg;
    logic         zero_reg;

    always_comb begin
        rotate    = (ctl_in.op == OP_ROR) || (ctl_in.op == OP_ROL);
        data_next = data_in;
        if (amt_in[0]) begin
            data_next = rotate ? {data_in[SHIFT-1:0], data_in[N-1:SHIFT]}
                               : {{SHIFT{ctl_in.fill}}, data_in[N-1:SHIFT]};
        end
    end

    // The zero flag is registered alongside the data so the output never decodes it combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_reg <= '0;
            amt_reg  <= '0;
            ctl_reg  <= '0;
            zero_reg <= 1'b0;
        end else if (adv) begin
            data_reg <= data_next;
            amt_reg  <= amt_in >> 1;
            ctl_reg  <= ctl_in;
            zero_reg <= (data_next == '0);
        end
    end

    assign data_out = data_reg;
    assign amt_out  = amt_reg;
    assign ctl_out  = ctl_reg;
    assign zero_out = zero_reg;

endmodule

// File: rtl/alu_shift_rotate_pipe.sv
// Pipelined N-bit rotate/shift unit with carry, zero and illegal-op flags and a
// single global advance for valid/ready backpressure.
module alu_shift_rotate_pipe
    import alu_shift_pkg::*;
#(
    parameter int N  = 8,
    localparam int S = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_a,
    input  logic [S-1:0] in_amt,
    input  logic [2:0]   in_op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_y,
    output logic         out_carry,
    output logic         out_zero,
    output logic         out_err
);

    if (N < 2 || (N & (N - 1)) != 0 || N > MAX_N) begin : g_bad_width
        $fatal(1, "alu_shift_rotate_pipe: N must be a power of two between 2 and %0d", MAX_N);
    end

    logic         adv;
    logic         is_err;
    logic         is_shift;
    logic [N-1:0] data0;
    logic [S-1:0] amt0;
    stage_ctl_t   ctl0;

    logic [N-1:0] st_data [0:S];
    logic [S-1:0] st_amt  [0:S];
    stage_ctl_t   st_ctl  [0:S];
    logic         st_zero [1:S];

    // Bubbles are not collapsed: the whole pipe moves together or not at all.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // ROL becomes ROR by (N-k) mod N; SLL runs as SRL on reversed data.
    always_comb begin
        is_err   = (in_op > 3'd4);
        is_shift = (in_op == OP_SRL) || (in_op == OP_SLL) || (in_op == OP_SRA);
        data0    = (in_op == OP_SLL) ? N'(bit_reverse(MAX_N'(in_a), N)) : in_a;
        amt0     = '0;
        if (!is_err) amt0 = (in_op == OP_ROL) ? S'(0) - in_amt : in_amt;
        ctl0       = '0;
        ctl0.valid = in_valid;
        ctl0.op    = shift_op_e'(in_op);
        ctl0.fill  = (in_op == OP_SRA) && in_a[N-1];
        ctl0.carry = is_shift && (in_amt != '0) && data0[in_amt - S'(1)];
        ctl0.err   = is_err;
        ctl0.rev   = (in_op == OP_SLL);
    end

    assign st_data[0] = data0;
    assign st_amt[0]  = amt0;
    assign st_ctl[0]  = ctl0;

    for (genvar gi = 0; gi < S; gi++) begin : g_stage
        alu_shift_stage #(
            .N     (N),
            .SHIFT (1 << gi)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .adv      (adv),
            .data_in  (st_data[gi]),
            .amt_in   (st_amt[gi]),
            .ctl_in   (st_ctl[gi]),
            .data_out (st_data[gi+1]),
            .amt_out  (st_amt[gi+1]),
            .ctl_out  (st_ctl[gi+1]),
            .zero_out (st_zero[gi+1])
        );
    end

    assign out_valid = st_ctl[S].valid;
    assign out_carry = st_ctl[S].carry;
    assign out_err   = st_ctl[S].err;
    assign out_zero  = st_zero[S];
    assign out_y     = st_ctl[S].rev ? N'(bit_reverse(MAX_N'(st_data[S]), N)) : st_data[S];

endmodule

// File: tb/tb_alu_shift_rotate_pipe.sv
// Scoreboarded bench for alu_shift_rotate_pipe at N=8: directed ops, a random
// backpressure stream, stall hold checks and reset with beats in flight.
module tb_alu_shift_rotate_pipe;

    localparam int N = 8;
    localparam int S = $clog2(N);

    typedef struct packed {
        logic [N-1:0] y;
        logic         carry;
        logic         zero;
        logic         err;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] in_a = '0;
    logic [S-1:0] in_amt = '0;
    logic [2:0]   in_op = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [N-1:0] out_y;
    logic         out_carry;
    logic         out_zero;
    logic         out_err;

    int   checks = 0;
    int   errors = 0;
    int   beat_no = 0;
    int   ready_mode = 0;
    exp_t sb[$];
    logic prev_stall = 1'b0;
    exp_t held;

    always #5 clk = ~clk;

    alu_shift_rotate_pipe #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_amt    (in_amt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_carry (out_carry),
        .out_zero  (out_zero),
        .out_err   (out_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [N-1:0] a, input logic [S-1:0] amt, input logic [2:0] op);
        exp_t e;
        e.y     = a;
        e.carry = 1'b0;
        e.err   = (op > 3'd4);
        if (!e.err && amt != 0) begin
            case (op)
                3'd0: e.y = (a >> amt) | (a << (N - amt));
                3'd1: e.y = (a << amt) | (a >> (N - amt));
                3'd2: begin e.y = a >> amt; e.carry = a[amt-1]; end
                3'd3: begin e.y = a << amt; e.carry = a[N-amt]; end
                default: begin e.y = $signed(a) >>> amt; e.carry = a[amt-1]; end
            endcase
        end
        e.zero = (e.y == 0);
        return e;
    endfunction

    // out_ready driver: 0 = always ready, 1 = random, otherwise stalled
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    // Output monitor: handshake, hold-while-stalled and in-order scoreboard compare.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            chk("in_ready_adv", in_ready, !out_valid || out_ready);
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_y", out_y, held.y);
                chk("hold_flags", {out_carry, out_zero, out_err}, {held.carry, held.zero, held.err});
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", out_valid, 0);
                end else begin
                    e = sb.pop_front();
                    beat_no++;
                    $display("beat %0d: y=%h carry=%b zero=%b err=%b (exp y=%h carry=%b zero=%b err=%b)",
                             beat_no, out_y, out_carry, out_zero, out_err, e.y, e.carry, e.zero, e.err);
                    chk("y", out_y, e.y);
                    chk("carry", out_carry, e.carry);
                    chk("zero", out_zero, e.zero);
                    chk("err", out_err, e.err);
                end
            end
            prev_stall = out_valid && !out_ready;
            held = '{out_y, out_carry, out_zero, out_err};
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents a beat, waits for acceptance, records the expected result.
    task automatic send_e(input logic [N-1:0] a, input logic [S-1:0] amt, input logic [2:0] op, input exp_t e);
        int waited;
        waited = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_amt   = amt;
        in_op    = op;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk("accept_timeout", in_ready, 1);
        if (in_ready) sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_m(input logic [N-1:0] a, input logic [S-1:0] amt, input logic [2:0] op);
        send_e(a, amt, op, model(a, amt, op));
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 200) begin
            @(posedge clk);
            w++;
        end
        tick(1);
        chk("drain", sb.size(), 0);
    endtask

    initial begin
        // Reset state
        #1 rst = 1'b1;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_y", out_y, 0);
        chk("rst_carry", out_carry, 0);
        chk("rst_zero", out_zero, 0);
        chk("rst_err", out_err, 0);
        chk("rst_in_ready", in_ready, 1);
        tick(3);
        rst = 1'b0;
        tick(1);

        // ROR 0x81 by 1 with latency of exactly three edges from acceptance
        send_e(8'h81, 3'd1, 3'd0, '{8'hC0, 1'b0, 1'b0, 1'b0});
        chk("lat_edge1", out_valid, 0);
        tick(1);
        chk("lat_edge2", out_valid, 0);
        tick(1);
        chk("lat_edge3", out_valid, 1);
        drain();

        // Directed ops, back to back
        send_e(8'h81, 3'd3, 3'd1, '{8'h0C, 1'b0, 1'b0, 1'b0});
        send_e(8'h81, 3'd1, 3'd3, '{8'h02, 1'b1, 1'b0, 1'b0});
        send_e(8'h01, 3'd1, 3'd2, '{8'h00, 1'b1, 1'b1, 1'b0});
        send_e(8'h80, 3'd7, 3'd4, '{8'hFF, 1'b0, 1'b0, 1'b0});
        for (int op = 0; op < 5; op++) begin
            send_e(8'hA5, 3'd0, 3'(op), '{8'hA5, 1'b0, 1'b0, 1'b0});
        end
        send_e(8'h5A, 3'd3, 3'd6, '{8'h5A, 1'b0, 1'b0, 1'b1});
        send_e(8'h5A, 3'd2, 3'd2, '{8'h16, 1'b1, 1'b0, 1'b0});
        send_e(8'h81, 3'd1, 3'd3, model(8'h81, 3'd1, 3'd3));
        drain();

        // Output held while stalled
        ready_mode = 2;
        send_m(8'h3C, 3'd5, 3'd0);
        tick(6);
        chk("stall_valid", out_valid, 1);
        ready_mode = 0;
        drain();

        // Random stream under random backpressure
        ready_mode = 1;
        for (int i = 0; i < 8; i++) begin
            send_m(8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end
        ready_mode = 0;
        drain();

        // Reset with beats in flight
        send_m(8'h11, 3'd1, 3'd0);
        send_m(8'h22, 3'd2, 3'd2);
        send_m(8'h33, 3'd3, 3'd3);
        chk("pre_rst_valid", out_valid, 1);
        #1 rst = 1'b1;
        #1;
        chk("rst_async_valid", out_valid, 0);
        chk("rst_async_y", out_y, 0);
        sb.delete();
        tick(2);
        chk("rst_hold_in_ready", in_ready, 1);
        rst = 1'b0;
        tick(5);
        chk("no_stale", out_valid, 0);

        send_e(8'h80, 3'd7, 3'd4, '{8'hFF, 1'b0, 1'b0, 1'b0});
        chk("relat_edge1", out_valid, 0);
        tick(1);
        chk("relat_edge2", out_valid, 0);
        tick(1);
        chk("relat_edge3", out_valid, 1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
